uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_baud_timer.sv | 27 ++
 rtl/uart_tx_framed.sv | 138 +++++++++++++
 tb/tb_uart_tx_framed.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity_mode encodings and the
// bit-period helper, kept here so the matching receiver can reuse them.
package uart_pkg;

    localparam int TIMER_W = 19;

    localparam logic [2:0] PARITY_NONE  = 3'd0;
    localparam logic [2:0] PARITY_EVEN  = 3'd1;
    localparam logic [2:0] PARITY_ODD   = 3'd2;
    localparam logic [2:0] PARITY_MARK  = 3'd3;
    localparam logic [2:0] PARITY_SPACE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Encodings 5..7 fall through to "no parity bit".
    function automatic logic parity_enabled(input logic [2:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD) ||
               (mode == PARITY_MARK) || (mode == PARITY_SPACE);
    endfunction

    function automatic logic parity_value(input logic [2:0] mode, input logic data_xor);
        logic value;
        value = 1'b0;
        case (mode)
            PARITY_EVEN: value = data_xor;
            PARITY_ODD:  value = ~data_xor;
            PARITY_MARK: value = 1'b1;
            default:     value = 1'b0;
        endcase
        return value;
    endfunction

    // One bit lasts prescale*8 clocks; a prescale of zero behaves like one.
    function automatic logic [TIMER_W-1:0] bit_period(input logic [15:0] prescale);
        logic [15:0] eff;
        eff = (prescale == 16'd0) ? 16'd1 : prescale;
        return {eff, 3'b000};
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period down-counter: load starts a period of 'period' clocks and done
// is high during the last clock of that period.
module uart_baud_timer
    import uart_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] period,
    output logic               done
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= (period == '0) ? '0 : period - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else if (count != '0) begin
            count <= count - {{(TIMER_W-1){1'b0}}, 1'b1};
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: AXI-stream character in, start/data/parity/stop
// frame out on txd with per-frame captured prescale, parity and stop config.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale,
    input  logic [2:0]            parity_mode,
    input  logic                  stop_bits
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    uart_state_t           state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [3:0]            bit_cnt;
    logic [TIMER_W-1:0]    period_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;

    logic                  handshake;
    logic                  timer_load;
    logic [TIMER_W-1:0]    timer_period;
    logic                  timer_done;

    assign handshake = s_axis_tvalid & s_axis_tready;

    // Each bit boundary reloads the timer; the very first load uses the live
    // prescale because the captured copy is only written on that same edge.
    assign timer_load   = handshake | ((state != ST_IDLE) & timer_done);
    assign timer_period = (state == ST_IDLE) ? bit_period(prescale) : period_q;

    uart_baud_timer u_baud_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .period (timer_period),
        .done   (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            txd           <= 1'b1;
            busy          <= 1'b0;
            s_axis_tready <= 1'b0;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            period_q      <= '0;
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            stop2_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    s_axis_tready <= 1'b1;
                    if (handshake) begin
                        shift_reg     <= s_axis_tdata;
                        period_q      <= bit_period(prescale);
                        par_en_q      <= parity_enabled(parity_mode);
                        par_bit_q     <= parity_value(parity_mode, ^s_axis_tdata);
                        stop2_q       <= stop_bits;
                        txd           <= 1'b0;
                        busy          <= 1'b1;
                        s_axis_tready <= 1'b0;
                        state         <= ST_START;
                    end
                end

                ST_START: begin
                    if (timer_done) begin
                        txd       <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= LAST_BIT;
                        state     <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (timer_done) begin
                        if (bit_cnt == 4'd0) begin
                            bit_cnt <= {3'b000, stop2_q};
                            if (par_en_q) begin
                                txd   <= par_bit_q;
                                state <= ST_PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            txd       <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
                            bit_cnt   <= bit_cnt - 4'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (timer_done) begin
                        txd     <= 1'b1;
                        bit_cnt <= {3'b000, stop2_q};
                        state   <= ST_STOP;
                    end
                end

                // bit_cnt counts the remaining extra stop periods (0 or 1).
                ST_STOP: begin
                    if (timer_done) begin
                        if (bit_cnt == 4'd0) begin
                            busy          <= 1'b0;
                            s_axis_tready <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end
                end

                default: begin
                    txd           <= 1'b1;
                    busy          <= 1'b0;
                    s_axis_tready <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench for uart_tx_framed: table of frames plus hand-written
// back-to-back, prescale-change and mid-frame reset sequences.
module tb_uart_tx_framed;

    localparam int DW      = 8;
    localparam int TIMEOUT = 20000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          txd;
    logic          busy;
    logic [15:0]   prescale;
    logic [2:0]    parity_mode;
    logic          stop_bits;

    typedef struct {
        logic [DW-1:0] data;
        logic [15:0]   ps;
        logic [2:0]    pm;
        logic          sb;
        logic          has_par;
        logic          par_bit;
        int            len;
    } vec_t;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          bitper;
        int          len;
    } exp_t;

    exp_t sb_q[$];
    int   start_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   frame_id = 0;
    bit   mon_active = 1'b0;
    vec_t vecs[11];

    uart_tx_framed #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .busy          (busy),
        .prescale      (prescale),
        .parity_mode   (parity_mode),
        .stop_bits     (stop_bits)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic exp_t make_exp(input vec_t v);
        exp_t e;
        int   k;
        e.bits = '1;
        k = 0;
        e.bits[k] = 1'b0;
        k++;
        for (int i = 0; i < DW; i++) begin
            e.bits[k] = v.data[i];
            k++;
        end
        if (v.has_par) begin
            e.bits[k] = v.par_bit;
            k++;
        end
        e.bits[k] = 1'b1;
        k++;
        if (v.sb) begin
            e.bits[k] = 1'b1;
            k++;
        end
        e.nbits  = k;
        e.bitper = ((v.ps == 16'd0) ? 1 : int'(v.ps)) * 8;
        e.len    = v.len;
        return e;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic checkOutput(input string name, input logic e_txd, input logic e_busy,
                               input logic e_rdy);
        checks++;
        if (txd !== e_txd || busy !== e_busy || s_axis_tready !== e_rdy) begin
            errors++;
            $display("[TB] FAIL %s: txd=%b busy=%b tready=%b expected txd=%b busy=%b tready=%b",
                     name, txd, busy, s_axis_tready, e_txd, e_busy, e_rdy);
        end
    endtask

    // Drives one character and queues its expected frame at the handshake.
    task automatic applyStimulus(input vec_t v, input bit hold);
        int n;
        s_axis_tdata  = v.data;
        prescale      = v.ps;
        parity_mode   = v.pm;
        stop_bits     = v.sb;
        s_axis_tvalid = 1'b1;
        n = 0;
        while (s_axis_tready !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake timeout: tready=%b expected 1", s_axis_tready);
            s_axis_tvalid = 1'b0;
        end else begin
            sb_q.push_back(make_exp(v));
            @(posedge clk);
            #1;
            if (!hold) s_axis_tvalid = 1'b0;
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mon_active) && n < TIMEOUT) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= TIMEOUT) begin
            errors++;
            $display("[TB] FAIL %s drain: %0d frames pending, expected 0", name, sb_q.size());
        end
    endtask

    // Monitor: on each rising busy, pops the expected frame and compares txd
    // cycle by cycle, reporting once per bit, then checks the return to idle.
    initial begin : monitor
        exp_t e;
        logic prev;
        logic expb;
        bit   bad;
        bit   aborted;
        logic bad_txd, bad_busy, bad_rdy;
        int   bad_c, idx;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && busy === 1'b1 && !prev) begin
                start_log.push_back(cycle);
                frame_id++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected frame %0d: busy=1 expected 0", frame_id);
                    prev = 1'b1;
                end else begin
                    e = sb_q.pop_front();
                    mon_active = 1'b1;
                    aborted = 1'b0;
                    bad = 1'b0;
                    bad_txd = 1'b0; bad_busy = 1'b0; bad_rdy = 1'b0; bad_c = 0;
                    for (int c = 0; c < e.len && !aborted; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                        end else begin
                            idx  = c / e.bitper;
                            expb = (idx < e.nbits) ? e.bits[idx] : 1'b1;
                            if (!bad && (txd !== expb || busy !== 1'b1 || s_axis_tready !== 1'b0)) begin
                                bad = 1'b1;
                                bad_txd = txd; bad_busy = busy; bad_rdy = s_axis_tready; bad_c = c;
                            end
                            if ((c % e.bitper) == e.bitper - 1 || c == e.len - 1) begin
                                checks++;
                                if (bad) begin
                                    errors++;
                                    $display("[TB] FAIL frame %0d bit %0d: txd=%b busy=%b tready=%b at cycle %0d, expected txd=%b busy=1 tready=0",
                                             frame_id, idx, bad_txd, bad_busy, bad_rdy, bad_c,
                                             e.bits[bad_c / e.bitper]);
                                end
                                bad = 1'b0;
                            end
                        end
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (rst_n === 1'b1) begin
                            checks++;
                            if (busy !== 1'b0 || s_axis_tready !== 1'b1) begin
                                errors++;
                                $display("[TB] FAIL frame %0d end after %0d cycles: busy=%b tready=%b expected busy=0 tready=1",
                                         frame_id, e.len, busy, s_axis_tready);
                            end
                        end
                        prev = (busy === 1'b1);
                    end else begin
                        prev = 1'b0;
                    end
                    mon_active = 1'b0;
                end
            end else begin
                prev = (rst_n === 1'b1 && busy === 1'b1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int   base;
        vec_t v;

        //           data   ps     pm    sb    par?  pbit  length
        vecs[0]  = '{8'h55, 16'd1, 3'd0, 1'b0, 1'b0, 1'b0, 80};
        vecs[1]  = '{8'h07, 16'd2, 3'd1, 1'b1, 1'b1, 1'b1, 192};
        vecs[2]  = '{8'h07, 16'd1, 3'd2, 1'b0, 1'b1, 1'b0, 88};
        vecs[3]  = '{8'h07, 16'd1, 3'd3, 1'b0, 1'b1, 1'b1, 88};
        vecs[4]  = '{8'h07, 16'd1, 3'd4, 1'b0, 1'b1, 1'b0, 88};
        vecs[5]  = '{8'h07, 16'd1, 3'd6, 1'b0, 1'b0, 1'b0, 80};
        vecs[6]  = '{8'h00, 16'd1, 3'd1, 1'b0, 1'b1, 1'b0, 88};
        vecs[7]  = '{8'hFF, 16'd0, 3'd2, 1'b1, 1'b1, 1'b1, 96};
        vecs[8]  = '{8'hA5, 16'd3, 3'd5, 1'b1, 1'b0, 1'b0, 264};
        vecs[9]  = '{8'h3C, 16'd1, 3'd7, 1'b0, 1'b0, 1'b0, 80};
        vecs[10] = '{8'h80, 16'd1, 3'd1, 1'b1, 1'b1, 1'b1, 96};

        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        prescale      = 16'd1;
        parity_mode   = 3'd0;
        stop_bits     = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset state", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("release before edge", 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("tready after first edge", 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], 1'b0);
            waitDrain($sformatf("vector %0d", i));
        end

        // Back-to-back frames with tvalid held: next start follows the
        // single handshake cycle after the stop period.
        base = start_log.size();
        v = '{8'hA5, 16'd1, 3'd0, 1'b0, 1'b0, 1'b0, 80};
        applyStimulus(v, 1'b1);
        v = '{8'h3C, 16'd1, 3'd0, 1'b0, 1'b0, 1'b0, 80};
        applyStimulus(v, 1'b0);
        waitDrain("back-to-back");
        if (start_log.size() >= base + 2)
            checkVal("back-to-back start spacing", start_log[base+1] - start_log[base], 81);
        else
            checkVal("back-to-back frame count", start_log.size() - base, 2);

        // Prescale (and tdata) change while the first frame is in flight.
        base = start_log.size();
        v = '{8'h5A, 16'd4, 3'd0, 1'b0, 1'b0, 1'b0, 320};
        applyStimulus(v, 1'b1);
        v = '{8'hC3, 16'd1, 3'd1, 1'b0, 1'b1, 1'b0, 88};
        applyStimulus(v, 1'b0);
        waitDrain("prescale change");
        if (start_log.size() >= base + 2)
            checkVal("prescale change start spacing", start_log[base+1] - start_log[base], 321);
        else
            checkVal("prescale change frame count", start_log.size() - base, 2);

        // Reset pulse during data bit 3 of 0x55 (cycle 34 of the frame).
        v = '{8'h55, 16'd1, 3'd0, 1'b0, 1'b0, 1'b0, 80};
        applyStimulus(v, 1'b0);
        repeat (34) @(posedge clk);
        #3;
        checkOutput("mid data bit 3", 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset mid-frame", 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("held in reset", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset release", 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("tready after release", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle stable", 1'b1, 1'b0, 1'b1);
        end
        checkVal("abandoned frame pending", sb_q.size(), 0);
        v = '{8'hC6, 16'd2, 3'd2, 1'b1, 1'b1, 1'b1, 192};
        applyStimulus(v, 1'b0);
        waitDrain("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
